// File: rtl/fetch_if.sv
// fetch_if: instruction-memory read port and decoded-instruction handshake of the fetch stage.
interface fetch_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] instr;
   logic [6:0]      opcode;
   logic [XLEN-1:0] pc_out;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   modport master (
      output imem_req, imem_addr, inst_valid, instr, opcode, pc_out,
      input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
   );
   modport slave (
      input  imem_req, imem_addr, inst_valid, instr, opcode, pc_out,
      output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage, one outstanding word read, valid/ready instruction output, PC redirect.
module fetch_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input logic     clk,
   input logic     rst,
   fetch_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
   state_t          state_q;
   logic [XLEN-1:0] pc_q, instr_q, pc_out_q, tgt;
   logic            req_q, valid_q;
   assign tgt            = bus.redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = pc_q;
   assign bus.inst_valid = valid_q;
   assign bus.instr      = instr_q;
   assign bus.opcode     = instr_q[6:0];
   assign bus.pc_out     = pc_out_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         req_q    <= 1'b0;
         valid_q  <= 1'b0;
         instr_q  <= NOP_INSTR;
         pc_out_q <= RESET_PC;
      end else begin
         req_q <= 1'b0;
         if (bus.redirect) pc_q <= tgt;
         if (bus.redirect && state_q != IDLE) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
         end
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: state_q <= bus.redirect ? DRAIN : WAIT;
            WAIT: begin
               if (bus.redirect) begin
                  state_q <= bus.imem_rvalid ? REQ : DRAIN;
                  req_q   <= bus.imem_rvalid;
               end else if (bus.imem_rvalid) begin
                  instr_q  <= bus.imem_rdata;
                  pc_out_q <= pc_q;
                  valid_q  <= 1'b1;
                  pc_q     <= pc_q + XLEN'(4);
                  state_q  <= HOLD;
               end
            end
            HOLD: begin
               if (bus.redirect || (valid_q && bus.inst_ready)) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            // A redirect here only retargets pc; the stale response still has to be absorbed.
            DRAIN: begin
               if (bus.imem_rvalid) begin
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard checked by a monitor on each new valid instruction.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   fetch_if #(.XLEN(32)) b ();
   fetch_if #(.XLEN(32)) b2 ();
   fetch_unit u_dut (.clk(clk), .rst(rst), .bus(b.master));
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst(rst), .bus(b2.master));
   typedef struct {logic [31:0] instr; logic [31:0] pc;} exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int lat = 1;
   int cnt = 0;
   logic [31:0] maddr = '0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr = '0;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Memory model: one response per request, lat cycles later, driven at the falling edge.
   initial begin
      b.imem_rvalid = 1'b0;
      b.imem_rdata  = '0;
      forever begin
         @(negedge clk);
         b.imem_rvalid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               b.imem_rvalid = 1'b1;
               b.imem_rdata  = ovr_en ? ovr : mem_word(maddr);
               ovr_en        = 1'b0;
            end
         end
         if (b.imem_req === 1'b1) begin
            cnt   = lat;
            maddr = b.imem_addr;
         end
      end
   end
   initial begin
      exp_t e;
      logic pv;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (b.inst_valid === 1'b1 && !pv) begin
            if (q.size() == 0) begin
               chk("unexpected_valid_instr", b.instr, 32'h0000_0013);
            end else begin
               e = q.pop_front();
               chk("sb_instr", b.instr, e.instr);
               chk("sb_opcode", 32'(b.opcode), 32'(e.instr[6:0]));
               chk("sb_pc_out", b.pc_out, e.pc);
            end
         end
         pv = (b.inst_valid === 1'b1);
      end
   end
   initial begin
      rst = 1'b1;
      b.inst_ready = 1'b0; b.redirect = 1'b0; b.redirect_pc = '0;
      b2.inst_ready = 1'b0; b2.redirect = 1'b0; b2.redirect_pc = '0;
      b2.imem_rvalid = 1'b0; b2.imem_rdata = '0;
      step(); step();
      chk("rst_req", 32'(b.imem_req), 0);
      chk("rst_valid", 32'(b.inst_valid), 0);
      chk("rst_instr", b.instr, 32'h0000_0013);
      chk("rst_opcode", 32'(b.opcode), 32'h13);
      chk("rst_pc_out", b.pc_out, 0);
      chk("rst_addr", b.imem_addr, 0);
      chk("wrap_rst_addr", b2.imem_addr, 32'hFFFF_FFFC);
      chk("wrap_rst_pc_out", b2.pc_out, 32'hFFFF_FFFC);
      q.push_back('{32'h0050_0093, 32'h0});
      rst = 1'b0;
      step();
      chk("first_req", 32'(b.imem_req), 1);
      chk("first_addr", b.imem_addr, 0);
      step();
      chk("req_one_cycle", 32'(b.imem_req), 0);
      step();
      chk("first_valid", 32'(b.inst_valid), 1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", 32'(b.inst_valid), 1);
         chk("hold_instr", b.instr, 32'h0050_0093);
         chk("hold_pc_out", b.pc_out, 0);
         chk("hold_no_req", 32'(b.imem_req), 0);
      end
      q.push_back('{32'h0000_0413, 32'h4});
      b.inst_ready = 1'b1;
      step();
      b.inst_ready = 1'b0;
      chk("consume_valid_drop", 32'(b.inst_valid), 0);
      chk("next_req", 32'(b.imem_req), 1);
      chk("next_addr", b.imem_addr, 32'h4);
      step(); step();
      chk("second_valid", 32'(b.inst_valid), 1);
      lat = 2; ovr_en = 1'b1; ovr = 32'hDEAD_BEEF;
      b.inst_ready = 1'b1;
      step();
      b.inst_ready = 1'b0;
      chk("third_addr", b.imem_addr, 32'h8);
      step();
      b.redirect = 1'b1; b.redirect_pc = 32'h0000_0102;
      step();
      b.redirect = 1'b0;
      lat = 1;
      chk("drain_valid", 32'(b.inst_valid), 0);
      chk("drain_no_req", 32'(b.imem_req), 0);
      chk("redirect_addr", b.imem_addr, 32'h0000_0100);
      step();
      chk("after_drain_req", 32'(b.imem_req), 1);
      chk("after_drain_addr", b.imem_addr, 32'h0000_0100);
      q.push_back('{32'h0001_0013, 32'h100});
      step(); step();
      chk("redirected_valid", 32'(b.inst_valid), 1);
      q.push_back('{32'h0000_4013, 32'h40});
      b.inst_ready = 1'b1; b.redirect = 1'b1; b.redirect_pc = 32'h40;
      step();
      b.inst_ready = 1'b0; b.redirect = 1'b0;
      chk("hold_redirect_valid", 32'(b.inst_valid), 0);
      chk("hold_redirect_instr", b.instr, 32'h0000_0013);
      chk("hold_redirect_req", 32'(b.imem_req), 1);
      chk("hold_redirect_addr", b.imem_addr, 32'h40);
      step(); step();
      chk("target_valid", 32'(b.inst_valid), 1);
      lat = 2;
      b.inst_ready = 1'b1;
      step();
      b.inst_ready = 1'b0;
      chk("pre_rst_addr", b.imem_addr, 32'h44);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      lat = 1;
      chk("midrst_valid", 32'(b.inst_valid), 0);
      chk("midrst_req", 32'(b.imem_req), 0);
      chk("midrst_addr", b.imem_addr, 0);
      q.push_back('{32'h0050_0093, 32'h0});
      step();
      chk("post_rst_req", 32'(b.imem_req), 1);
      chk("post_rst_addr", b.imem_addr, 0);
      chk("stale_ignored", 32'(b.inst_valid), 0);
      step(); step();
      chk("post_rst_valid", 32'(b.inst_valid), 1);
      b2.imem_rvalid = 1'b1; b2.imem_rdata = 32'h00A0_0113;
      step();
      b2.imem_rvalid = 1'b0;
      chk("wrap_valid", 32'(b2.inst_valid), 1);
      chk("wrap_instr", b2.instr, 32'h00A0_0113);
      chk("wrap_pc_out", b2.pc_out, 32'hFFFF_FFFC);
      chk("wrap_pc", b2.imem_addr, 0);
      b2.inst_ready = 1'b1;
      step();
      b2.inst_ready = 1'b0;
      chk("wrap_req", 32'(b2.imem_req), 1);
      chk("wrap_req_addr", b2.imem_addr, 0);
      step(); step();
      chk("sb_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32I core.
- Holds the PC, issues word reads to instruction memory and captures the returned instruction.
- Presents the captured instruction, its 7-bit opcode and its PC to the type decoder and control path through a valid/ready handshake.
- Accepts PC redirects from branch/jal/jalr resolution and discards any in-flight fetch on redirect.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction value held while nothing is valid (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request, asserted one cycle per fetch.
- imem_addr  output  XLEN  word-aligned fetch address; valid while imem_req=1.
- imem_rvalid  input  1  read data valid, one-cycle pulse.
- imem_rdata  input  XLEN  read data.
- inst_valid  output  1  instr/opcode/pc_out hold a valid instruction.
- inst_ready  input  1  downstream consumes the instruction this cycle.
- instr  output  XLEN  captured instruction.
- opcode  output  7  instr[6:0], driven to the type decoder.
- pc_out  output  XLEN  address of instr.
- redirect  input  1  load new PC, one-cycle pulse.
- redirect_pc  input  XLEN  target PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, instr=NOP_INSTR, opcode=7'b0010011, pc_out=RESET_PC. Reset has priority over every other input in the same cycle.
- All outputs are registered except opcode, which is always instr[6:0].
- imem_addr always equals pc.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: imem_req=0. Goes to REQ on the first clock edge with rst=0.
- REQ: imem_req=1 for exactly one cycle. Goes to WAIT. imem_rvalid is ignored in REQ.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4, go to HOLD.
- HOLD: instruction is held stable. On inst_valid&&inst_ready: inst_valid<=0, instr<=NOP_INSTR, go to REQ.
- Minimum latency: request to valid is 2 cycles with a 1-cycle memory. Back-to-back throughput is 1 instruction per 3 cycles.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Redirect has priority over the normal transition in every state except IDLE. In IDLE it only loads pc.
  - pc<={redirect_pc[XLEN-1:2],2'b00}.
  - inst_valid<=0 and instr<=NOP_INSTR.
  - From REQ, WAIT (rvalid not yet seen) or WAIT with simultaneous rvalid: response is dropped.
    - REQ or WAIT without rvalid: go to DRAIN.
    - WAIT with simultaneous rvalid: go to REQ.
  - From HOLD: go to REQ. A simultaneous inst_ready handshake counts as consumed.
  - From DRAIN: update pc and stay in DRAIN.
- DRAIN: wait for the stale imem_rvalid, discard its data, then go to REQ. inst_valid stays 0.
- The memory returns exactly one imem_rvalid per imem_req, at least 1 cycle after the request.
- Mid-operation reset returns to IDLE; any outstanding response arriving afterward is ignored, because IDLE and REQ ignore rvalid.
- instr, opcode and pc_out must not change while inst_valid=1 and inst_ready=0.

Test Plan:
- Reset then 1-cycle memory returning 32'h00500093 -> imem_req at cycle 2 with addr 0; inst_valid=1 with instr=32'h00500093, opcode=7'b0010011 and pc_out=0 two cycles later; next fetch addr 4 after inst_ready.
- inst_ready held low 5 cycles in HOLD -> instr, pc_out and inst_valid stable, no imem_req. Ready pulse -> inst_valid drops, imem_req with addr 4 the next cycle.
- Redirect to 32'h0000_0102 while in WAIT, rvalid 2 cycles later with 32'hDEADBEEF -> DEADBEEF never appears with inst_valid=1; next imem_addr=32'h0000_0100.
- Redirect simultaneous with inst_valid&&inst_ready in HOLD, target 32'h40 -> inst_valid=0 the next cycle, then imem_req with addr 32'h40.
- RESET_PC=32'hFFFF_FFFC, one fetch completed -> next imem_addr=32'h0000_0000.
- rst asserted in WAIT, memory returns data 1 cycle later -> inst_valid stays 0, imem_addr=RESET_PC, fresh fetch after rst release.
